// File: rtl/sd_pkg.sv
// -----------------------------------------------------------------------------
// sd_pkg -- shared definitions for the SD SPI-mode command framer.
//
// Contents:
//   sd_state_e          framer FSM state encoding
//   SD_START_TX         start + transmission bits that lead every command byte
//   SD_FILL_BYTE        idle/fill byte clocked while polling for a response
//   CMD0 .. CMD24       command numbers used by the card controller
//   SD_CRC_CMD0/CMD8    precomputed {crc7, end} bytes for the two commands that
//                       cards check in SPI mode
//   sd_fixed_crc_byte() lookup used when the CRC7 engine is not built
// -----------------------------------------------------------------------------
package sd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SEND_ISSUE = 3'd1,
        ST_SEND_WAIT  = 3'd2,
        ST_POLL_ISSUE = 3'd3,
        ST_POLL_WAIT  = 3'd4,
        ST_RESP_ISSUE = 3'd5,
        ST_RESP_WAIT  = 3'd6,
        ST_FINISH     = 3'd7
    } sd_state_e;

    localparam logic [1:0] SD_START_TX  = 2'b01;
    localparam logic [7:0] SD_FILL_BYTE = 8'hFF;

    localparam logic [5:0] CMD0   = 6'd0;
    localparam logic [5:0] CMD8   = 6'd8;
    localparam logic [5:0] CMD17  = 6'd17;
    localparam logic [5:0] CMD24  = 6'd24;
    localparam logic [5:0] ACMD41 = 6'd41;
    localparam logic [5:0] CMD55  = 6'd55;
    localparam logic [5:0] CMD58  = 6'd58;

    localparam logic [31:0] SD_CMD8_ARG = 32'h0000_01AA;

    localparam logic [7:0] SD_CRC_CMD0    = 8'h95;
    localparam logic [7:0] SD_CRC_CMD8    = 8'h87;
    // Any byte with the end bit set; cards ignore the CRC once in SPI mode.
    localparam logic [7:0] SD_CRC_DEFAULT = 8'h01;

    // Index of the last frame byte (B5, the CRC/end byte).
    localparam logic [2:0] SD_LAST_FRAME_BYTE = 3'd5;

    // Last byte of the frame without a CRC engine: only CMD0 and CMD8 are
    // issued before the card stops checking CRCs, so two constants suffice.
    function automatic logic [7:0] sd_fixed_crc_byte(input logic [5:0]  idx,
                                                     input logic [31:0] arg);
        if (idx == CMD0 && arg == 32'h0)
            return SD_CRC_CMD0;
        else if (idx == CMD8 && arg == SD_CMD8_ARG)
            return SD_CRC_CMD8;
        else
            return SD_CRC_DEFAULT;
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// -----------------------------------------------------------------------------
// sd_crc7 -- byte-wide combinational CRC7 update, G(x) = x^7 + x^3 + 1,
// data consumed MSB first. Chain instances to cover a multi-byte message.
//
// Ports:
//   crc_in   [6:0]  running CRC before this byte
//   data     [7:0]  message byte
//   crc_out  [6:0]  running CRC after this byte
// -----------------------------------------------------------------------------
module sd_crc7 (
    input  logic [6:0] crc_in,
    input  logic [7:0] data,
    output logic [6:0] crc_out
);

    always_comb begin
        logic [6:0] c;
        logic       fb;
        c  = crc_in;
        fb = 1'b0;
        // Unrolled serial LFSR: one shift per data bit, MSB first.
        for (int i = 7; i >= 0; i--) begin
            fb = c[6] ^ data[i];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        crc_out = c;
    end

endmodule

// File: rtl/sd_cmd_framer.sv
// -----------------------------------------------------------------------------
// sd_cmd_framer -- builds the 6-byte SD SPI-mode command frame, streams it
// through the SPI byte engine, polls with fill bytes for R1 and optionally
// collects four trailing response bytes (R3/R7).
//
// Build option:
//   SD_CMD_CRC_EN  defined   -> CRC7 is computed over B0..B4 (sd_crc7 chain)
//                  undefined -> B5 comes from the sd_fixed_crc_byte() lookup
//
// Parameter:
//   MAX_POLL_BYTES  fill bytes allowed while waiting for R1 (1..255)
//
// Ports:
//   clk, rst_n          clock (registers update on its falling edge) and
//                       asynchronous active-low reset
//   cmd_start           request, only honoured in IDLE
//   cmd_index/cmd_arg   command number and argument, captured on acceptance
//   resp_long           collect 4 bytes after R1, captured on acceptance
//   busy / done         transaction in flight / one-cycle end pulse
//   r1 / resp_data      R1 byte (FF on timeout) / trailing bytes, first in MSB
//   timeout             no R1 within MAX_POLL_BYTES, valid with done
//   spi_execute         one-cycle byte-transfer request to the engine
//   spi_out_word        byte to send, stable from request to completion
//   spi_in_word         byte received, valid with spi_finished
//   spi_finished        engine completion pulse
//   spi_busy            engine cannot take a request
// -----------------------------------------------------------------------------
module sd_cmd_framer
    import sd_pkg::*;
#(
    parameter int MAX_POLL_BYTES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic        resp_long,
    output logic        busy,
    output logic        done,
    output logic [7:0]  r1,
    output logic [31:0] resp_data,
    output logic        timeout,
    output logic        spi_execute,
    output logic [7:0]  spi_out_word,
    input  logic [7:0]  spi_in_word,
    input  logic        spi_finished,
    input  logic        spi_busy
);

    localparam logic [7:0] MAX_POLL_W = 8'(MAX_POLL_BYTES);

    sd_state_e   state_q,        state_d;
    logic [2:0]  byte_idx_q,     byte_idx_d;
    logic [7:0]  poll_cnt_q,     poll_cnt_d;
    logic [1:0]  resp_cnt_q,     resp_cnt_d;
    logic [5:0]  cmd_index_q,    cmd_index_d;
    logic [31:0] cmd_arg_q,      cmd_arg_d;
    logic        resp_long_q,    resp_long_d;
    logic        busy_q,         busy_d;
    logic        done_q,         done_d;
    logic [7:0]  r1_q,           r1_d;
    logic [31:0] resp_data_q,    resp_data_d;
    logic        timeout_q,      timeout_d;
    logic        spi_execute_q,  spi_execute_d;
    logic [7:0]  spi_out_word_q, spi_out_word_d;

    // B0..B4 of the frame; B5 is derived from these.
    logic [39:0] frame_hdr;
    logic [7:0]  crc_byte;
    logic [7:0]  tx_byte;

    assign frame_hdr = {SD_START_TX, cmd_index_q, cmd_arg_q};

`ifdef SD_CMD_CRC_EN
    logic [6:0] crc_chain [0:5];

    assign crc_chain[0] = 7'h00;

    for (genvar g = 0; g < 5; g++) begin : g_crc
        sd_crc7 u_crc7 (
            .crc_in  (crc_chain[g]),
            .data    (frame_hdr[39-8*g -: 8]),
            .crc_out (crc_chain[g+1])
        );
    end

    assign crc_byte = {crc_chain[5], 1'b1};
`else
    assign crc_byte = sd_fixed_crc_byte(cmd_index_q, cmd_arg_q);
`endif

    always_comb begin
        case (byte_idx_q)
            3'd0:    tx_byte = frame_hdr[39:32];
            3'd1:    tx_byte = frame_hdr[31:24];
            3'd2:    tx_byte = frame_hdr[23:16];
            3'd3:    tx_byte = frame_hdr[15:8];
            3'd4:    tx_byte = frame_hdr[7:0];
            3'd5:    tx_byte = crc_byte;
            default: tx_byte = SD_FILL_BYTE;
        endcase
    end

    // Next-state and output logic.
    always_comb begin
        // NOTE: every _d is given its hold value first so no path through the
        // case below leaves a variable unassigned (which would infer a latch).
        state_d        = state_q;
        byte_idx_d     = byte_idx_q;
        poll_cnt_d     = poll_cnt_q;
        resp_cnt_d     = resp_cnt_q;
        cmd_index_d    = cmd_index_q;
        cmd_arg_d      = cmd_arg_q;
        resp_long_d    = resp_long_q;
        busy_d         = busy_q;
        r1_d           = r1_q;
        resp_data_d    = resp_data_q;
        timeout_d      = timeout_q;
        spi_out_word_d = spi_out_word_q;
        // Pulses default low so they last exactly one cycle.
        spi_execute_d  = 1'b0;
        done_d         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_start) begin
                    cmd_index_d = cmd_index;
                    cmd_arg_d   = cmd_arg;
                    resp_long_d = resp_long;
                    busy_d      = 1'b1;
                    timeout_d   = 1'b0;
                    byte_idx_d  = 3'd0;
                    poll_cnt_d  = 8'd0;
                    state_d     = ST_SEND_ISSUE;
                end
            end

            ST_SEND_ISSUE: begin
                if (!spi_busy) begin
                    spi_out_word_d = tx_byte;
                    spi_execute_d  = 1'b1;
                    state_d        = ST_SEND_WAIT;
                end
            end

            ST_SEND_WAIT: begin
                // Bytes clocked back during the frame carry nothing useful.
                if (spi_finished) begin
                    byte_idx_d = byte_idx_q + 3'd1;
                    state_d    = (byte_idx_q == SD_LAST_FRAME_BYTE) ? ST_POLL_ISSUE
                                                                    : ST_SEND_ISSUE;
                end
            end

            ST_POLL_ISSUE, ST_RESP_ISSUE: begin
                if (!spi_busy) begin
                    spi_out_word_d = SD_FILL_BYTE;
                    spi_execute_d  = 1'b1;
                    state_d        = (state_q == ST_POLL_ISSUE) ? ST_POLL_WAIT
                                                                : ST_RESP_WAIT;
                end
            end

            ST_POLL_WAIT: begin
                if (spi_finished) begin
                    poll_cnt_d = poll_cnt_q + 8'd1;
                    if (!spi_in_word[7]) begin
                        // R1 always has its MSB clear; anything else is fill.
                        r1_d = spi_in_word;
                        if (resp_long_q) begin
                            resp_cnt_d = 2'd0;
                            state_d    = ST_RESP_ISSUE;
                        end else begin
                            done_d  = 1'b1;
                            state_d = ST_FINISH;
                        end
                    end else if (poll_cnt_q + 8'd1 == MAX_POLL_W) begin
                        r1_d      = SD_FILL_BYTE;
                        timeout_d = 1'b1;
                        done_d    = 1'b1;
                        state_d   = ST_FINISH;
                    end else begin
                        state_d = ST_POLL_ISSUE;
                    end
                end
            end

            ST_RESP_WAIT: begin
                if (spi_finished) begin
                    resp_data_d = {resp_data_q[23:0], spi_in_word};
                    resp_cnt_d  = resp_cnt_q + 2'd1;
                    if (resp_cnt_q == 2'd3) begin
                        done_d  = 1'b1;
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_RESP_ISSUE;
                    end
                end
            end

            ST_FINISH: begin
                // done is high for this one cycle; requests here are dropped.
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // The SPI engine launches on the rising edge, so this stage updates on the
    // falling edge to present stable requests half a cycle ahead.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            byte_idx_q     <= 3'd0;
            poll_cnt_q     <= 8'd0;
            resp_cnt_q     <= 2'd0;
            cmd_index_q    <= 6'd0;
            cmd_arg_q      <= 32'h0;
            resp_long_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            r1_q           <= SD_FILL_BYTE;
            resp_data_q    <= 32'h0;
            timeout_q      <= 1'b0;
            spi_execute_q  <= 1'b0;
            spi_out_word_q <= SD_FILL_BYTE;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state_q        <= state_d;
            byte_idx_q     <= byte_idx_d;
            poll_cnt_q     <= poll_cnt_d;
            resp_cnt_q     <= resp_cnt_d;
            cmd_index_q    <= cmd_index_d;
            cmd_arg_q      <= cmd_arg_d;
            resp_long_q    <= resp_long_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            r1_q           <= r1_d;
            resp_data_q    <= resp_data_d;
            timeout_q      <= timeout_d;
            spi_execute_q  <= spi_execute_d;
            spi_out_word_q <= spi_out_word_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign r1           = r1_q;
    assign resp_data    = resp_data_q;
    assign timeout      = timeout_q;
    assign spi_execute  = spi_execute_q;
    assign spi_out_word = spi_out_word_q;

endmodule
